// File: rtl/tile_sequencer_if.sv
// Tile sequencer bus: command handshake, operand load stream, buffer write
// ports, accumulator control and status. The master is the instruction
// decode side; the slave is the sequencer.
interface tile_sequencer_if #(
    parameter int ADDR_W     = 7,
    parameter int OUT_ADDR_W = 4,
    parameter int DATA_W     = 32
);
    // Command handshake
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_len;
    logic [OUT_ADDR_W-1:0] cmd_out_base;

    // Operand load stream
    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_W-1:0]     ld_data;

    // Operand buffer ports
    logic [ADDR_W-1:0]     wt_buf_addr;
    logic [DATA_W-1:0]     wt_buf_data;
    logic [ADDR_W-1:0]     inp_buf_addr;
    logic [DATA_W-1:0]     inp_buf_data;
    logic [1:0]            state_signal;

    // Accumulator / output buffer control
    logic                  acc_store;
    logic [OUT_ADDR_W-1:0] acc_op_addr;
    logic                  acc_reset;

    // Control and status
    logic                  abort;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_len, cmd_out_base, ld_valid, ld_data, abort,
        input  cmd_ready, ld_ready, wt_buf_addr, wt_buf_data, inp_buf_addr,
               inp_buf_data, state_signal, acc_store, acc_op_addr, acc_reset,
               busy, done
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_out_base, ld_valid, ld_data, abort,
        output cmd_ready, ld_ready, wt_buf_addr, wt_buf_data, inp_buf_addr,
               inp_buf_data, state_signal, acc_store, acc_op_addr, acc_reset,
               busy, done
    );
endinterface

// File: rtl/tile_sequencer.sv
// Tile sequencer: takes one tile command, streams len weight words then len
// input words into the operand buffers, runs the compute window (len plus
// skew fill/drain), stores ARR_SIZE accumulator rows to consecutive output
// addresses, clears the accumulators and pulses done.
//
// Buffer address/data ports are registers: a value issued in one cycle is
// on the port the next cycle. This holds for load beats and for compute
// read addresses alike, so the last input write is still visible on the
// port in the first compute cycle and the compute read sequence trails the
// compute counter by one cycle.
module tile_sequencer #(
    parameter int ARR_SIZE   = 4,
    parameter int ADDR_W     = 7,
    parameter int OUT_ADDR_W = 4,
    parameter int DATA_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    tile_sequencer_if.slave bus
);

    // Wide enough for the longest compute window: (2^ADDR_W - 1) + 2*ARR_SIZE - 2
    localparam int CNT_W = $clog2((1 << ADDR_W) + 2 * ARR_SIZE);

    localparam logic [1:0] SS_LOAD    = 2'b00;
    localparam logic [1:0] SS_COMPUTE = 2'b01;
    localparam logic [1:0] SS_DRAIN   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        COMPUTE,
        DRAIN,
        CLEAR,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     len_q;
    logic [OUT_ADDR_W-1:0] base_q;

    logic                  ld_beat;
    logic                  abort_now;
    logic                  load_last;
    logic                  compute_last;
    logic                  drain_last;
    logic [ADDR_W-1:0]     len_m1;
    logic [ADDR_W-1:0]     sat_addr;

    // Handshake readiness is decoded straight from state; abort blocks a beat
    assign bus.cmd_ready = (state == IDLE);
    assign bus.ld_ready  = ((state == LOAD_W) || (state == LOAD_I)) && !bus.abort;

    // Beat qualification, phase-end detection and saturated compute address
    always_comb begin
        ld_beat      = bus.ld_valid && bus.ld_ready;
        // CLEAR and DONE are already the wind-down path, so abort only
        // short-cuts the working phases
        abort_now    = bus.abort && (state inside {LOAD_W, LOAD_I, COMPUTE, DRAIN});
        len_m1       = len_q - ADDR_W'(1);
        load_last    = (cnt == CNT_W'(len_m1));
        compute_last = (cnt == CNT_W'(len_q) + CNT_W'(2 * ARR_SIZE - 3));
        drain_last   = (cnt == CNT_W'(ARR_SIZE - 1));
        sat_addr     = (cnt >= CNT_W'(len_m1)) ? len_m1 : cnt[ADDR_W-1:0];
    end

    // Tile FSM with registered outputs that change together with the state
    // NOTE: all sequential state uses non-blocking assignments so every
    // register in this block samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            len_q            <= '0;
            base_q           <= '0;
            bus.wt_buf_addr  <= '0;
            bus.wt_buf_data  <= '0;
            bus.inp_buf_addr <= '0;
            bus.inp_buf_data <= '0;
            bus.state_signal <= SS_LOAD;
            bus.acc_store    <= 1'b0;
            bus.acc_op_addr  <= '0;
            bus.acc_reset    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.acc_reset <= 1'b0;
            bus.done      <= 1'b0;

            if (abort_now) begin
                state            <= CLEAR;
                cnt              <= '0;
                bus.acc_store    <= 1'b0;
                bus.acc_reset    <= 1'b1;
                bus.state_signal <= SS_DRAIN;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.cmd_valid) begin
                            len_q    <= bus.cmd_len;
                            base_q   <= bus.cmd_out_base;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            if (bus.cmd_len == '0) begin
                                state            <= CLEAR;
                                bus.acc_reset    <= 1'b1;
                                bus.state_signal <= SS_DRAIN;
                            end else begin
                                state            <= LOAD_W;
                                bus.state_signal <= SS_LOAD;
                            end
                        end
                    end

                    LOAD_W: begin
                        if (ld_beat) begin
                            bus.wt_buf_addr <= cnt[ADDR_W-1:0];
                            bus.wt_buf_data <= bus.ld_data;
                            if (load_last) begin
                                state <= LOAD_I;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    LOAD_I: begin
                        if (ld_beat) begin
                            bus.inp_buf_addr <= cnt[ADDR_W-1:0];
                            bus.inp_buf_data <= bus.ld_data;
                            if (load_last) begin
                                state            <= COMPUTE;
                                cnt              <= '0;
                                bus.state_signal <= SS_COMPUTE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    COMPUTE: begin
                        bus.wt_buf_addr  <= sat_addr;
                        bus.inp_buf_addr <= sat_addr;
                        if (compute_last) begin
                            state            <= DRAIN;
                            cnt              <= '0;
                            bus.state_signal <= SS_DRAIN;
                            bus.acc_store    <= 1'b1;
                            bus.acc_op_addr  <= base_q;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    DRAIN: begin
                        if (drain_last) begin
                            state         <= CLEAR;
                            cnt           <= '0;
                            bus.acc_store <= 1'b0;
                            bus.acc_reset <= 1'b1;
                        end else begin
                            cnt             <= cnt + CNT_W'(1);
                            bus.acc_op_addr <= bus.acc_op_addr + OUT_ADDR_W'(1);
                        end
                    end

                    CLEAR: begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end

                    DONE: begin
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                        bus.state_signal <= SS_LOAD;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
